// File: rtl/ntt_pkg.sv
// Shared NTT constants, the MDC stage state encoding and modular add/sub/halve helpers.
package ntt_pkg;

  localparam int unsigned DATA_W = 23;
  localparam int unsigned Q      = 8380417;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

  function automatic logic [DATA_W-1:0] add_mod(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] q);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, q}) s = s - {1'b0, q};
    return s[DATA_W-1:0];
  endfunction

  // On borrow the modular wrap of a - b + q lands on the true value, which is below q.
  function automatic logic [DATA_W-1:0] sub_mod(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] q);
    if (a >= b) return a - b;
    return a - b + q;
  endfunction

  function automatic logic [DATA_W-1:0] half_mod(input logic [DATA_W-1:0] v,
                                                 input logic [DATA_W-1:0] q);
    logic [DATA_W:0] t;
    t = v[0] ? ({1'b0, v} + {1'b0, q}) : {1'b0, v};
    return t[DATA_W:1];
  endfunction

endpackage

// File: rtl/mod_red.sv
// Registered reduction of a 2*DATA_W product modulo Q; forms butterfly stage P3.
module mod_red
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_W = ntt_pkg::DATA_W,
  parameter int unsigned Q      = ntt_pkg::Q
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*DATA_W-1:0]   prod_i,
  output logic [DATA_W-1:0]     res_o
);

  localparam int unsigned PW = 2 * DATA_W;

  logic [DATA_W-1:0] res_d, res_q;

  always_comb begin
    res_d = DATA_W'(prod_i % PW'(Q));
  end

  always_ff @(posedge clk) begin
    if (!reset) res_q <= '0;
    else        res_q <= res_d;
  end

  assign res_o = res_q;

endmodule

// File: rtl/gs_r2mdc.sv
// Radix-2 MDC stage with Gentleman-Sande butterfly for the inverse NTT.
// Define GS_DIV2_EN to halve both outputs mod Q in the last pipeline stage.
module gs_r2mdc
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_W      = ntt_pkg::DATA_W,
  parameter int unsigned Q           = ntt_pkg::Q,
  parameter int unsigned D           = 1,
  parameter int unsigned FRAME_PAIRS = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           en,
  output logic                           in_ready,
  input  logic [DATA_W-1:0]              A_in,
  input  logic [DATA_W-1:0]              B_in,
  output logic [$clog2(FRAME_PAIRS)-1:0] tw_idx,
  input  logic [DATA_W-1:0]              zeta,
  output logic [DATA_W-1:0]              A_out,
  output logic [DATA_W-1:0]              B_out,
  output logic                           valid
);

  localparam int unsigned TW_W = $clog2(FRAME_PAIRS);
  localparam int unsigned SB   = $clog2(D);
  localparam int unsigned PW   = 2 * DATA_W;
  localparam logic [DATA_W-1:0] QW = DATA_W'(Q);

  state_e state_q, state_d;
  logic [TW_W-1:0] k_q, k_d, tw_q, tw_d;
  logic accept, last_acc, drain_end, issue_up, issue_lo, issue;
  logic [DATA_W-1:0] up_q [D];
  logic [DATA_W-1:0] up_d [D];
  logic [DATA_W-1:0] lo_q [2*D];
  logic [DATA_W-1:0] lo_d [2*D];
  logic [DATA_W-1:0] x, y;

  logic              v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic [DATA_W-1:0] a1_q, a1_d, d1_q, d1_d, z1_q, z1_d;
  logic [DATA_W-1:0] a2_q, a2_d, a3_q, a3_d, b3;
  logic [PW-1:0]     p2_q, p2_d;

  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = last_acc ? DRAIN : RUN;
      RUN:     if (last_acc) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Upper pairs issue on second-half accepts; lower pairs trail by one half-block or drain.
  always_comb begin
    in_ready  = (state_q != DRAIN);
    accept    = en && in_ready;
    last_acc  = accept && (32'(k_q) == FRAME_PAIRS - 1);
    drain_end = (state_q == DRAIN) && (32'(k_q) == D - 1);
    issue_up  = accept && k_q[SB];
    issue_lo  = (accept && !k_q[SB] && (32'(k_q) >= 2 * D)) || (state_q == DRAIN);
    issue     = issue_up || issue_lo;
  end

  always_comb begin
    k_d  = k_q;
    tw_d = tw_q;
    up_d = up_q;
    lo_d = lo_q;
    if (accept)               k_d = last_acc ? '0 : k_q + 1'b1;
    else if (state_q == DRAIN) k_d = drain_end ? '0 : k_q + 1'b1;
    if (issue) tw_d = (32'(tw_q) == FRAME_PAIRS - 1) ? '0 : tw_q + 1'b1;
    if (accept) begin
      up_d[0] = A_in;
      for (int unsigned i = 1; i < D; i++) up_d[i] = up_q[i-1];
    end
    if (accept || state_q == DRAIN) begin
      lo_d[0] = B_in;
      for (int unsigned i = 1; i < 2 * D; i++) lo_d[i] = lo_q[i-1];
    end
    x = issue_up ? up_q[D-1] : lo_q[2*D-1];
    y = issue_up ? A_in      : lo_q[D-1];
  end

  always_comb begin
    v1_d = issue;
    a1_d = add_mod(x, y, QW);
    d1_d = sub_mod(x, y, QW);
    z1_d = zeta;
    v2_d = v1_q;
    a2_d = a1_q;
    p2_d = PW'(d1_q) * PW'(z1_q);
    v3_d = v2_q;
    a3_d = a2_q;
  end

  always_ff @(posedge clk) begin
    up_q <= up_d;
    lo_q <= lo_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      k_q  <= '0;
      tw_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      a1_q <= '0;
      d1_q <= '0;
      z1_q <= '0;
      a2_q <= '0;
      p2_q <= '0;
      a3_q <= '0;
    end else begin
      k_q  <= k_d;
      tw_q <= tw_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      a1_q <= a1_d;
      d1_q <= d1_d;
      z1_q <= z1_d;
      a2_q <= a2_d;
      p2_q <= p2_d;
      a3_q <= a3_d;
    end
  end

  mod_red #(
    .DATA_W(DATA_W),
    .Q     (Q)
  ) u_mod_red (
    .clk   (clk),
    .reset (reset),
    .prod_i(p2_q),
    .res_o (b3)
  );

`ifdef GS_DIV2_EN
  assign A_out = half_mod(a3_q, QW);
  assign B_out = half_mod(b3, QW);
`else
  assign A_out = a3_q;
  assign B_out = b3;
`endif

  assign valid  = v3_q;
  assign tw_idx = tw_q;

endmodule

// File: tb/tb_gs_r2mdc.sv
// Self-checking bench for gs_r2mdc: three configurations against a frame-level reference model.
module tb_gs_r2mdc;

  localparam longint unsigned Q = 8380417;
  localparam int NI = 3;
  localparam int DV  [NI] = '{1, 4, 2};
  localparam int FPV [NI] = '{2, 8, 8};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en   [NI];
  logic [22:0] ain  [NI];
  logic [22:0] bin  [NI];
  logic [22:0] zeta [NI];
  logic [22:0] aout [NI];
  logic [22:0] bout [NI];
  logic        rdy  [NI];
  logic        vld  [NI];
  logic [2:0]  tw   [NI];
  logic [22:0] rom  [NI][8];

  logic [45:0] expbuf [NI][64];
  int          wr [NI];
  int          rd [NI];
  logic [45:0] e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_last = 0;
  int nv = 0;
  int vcyc [8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int TWW = $clog2(FPV[g]);
    logic [TWW-1:0] tw_l;
    gs_r2mdc #(
      .DATA_W     (23),
      .Q          (8380417),
      .D          (DV[g]),
      .FRAME_PAIRS(FPV[g])
    ) u_dut (
      .clk     (clk),
      .reset   (rst_n),
      .en      (en[g]),
      .in_ready(rdy[g]),
      .A_in    (ain[g]),
      .B_in    (bin[g]),
      .tw_idx  (tw_l),
      .zeta    (zeta[g]),
      .A_out   (aout[g]),
      .B_out   (bout[g]),
      .valid   (vld[g])
    );
    assign tw[g]   = 3'(tw_l);
    assign zeta[g] = rom[g][tw_l];
  end

  task automatic check_val(input string tag, input longint unsigned got, input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (vld[g] === 1'b1) begin
        if (rd[g] == wr[g]) begin
          check_val($sformatf("spurious_valid_%0d", g), 1, 0);
        end else begin
          e = expbuf[g][rd[g] % 64];
          rd[g]++;
          check_val($sformatf("A_out_%0d", g), aout[g], e[45:23]);
          check_val($sformatf("B_out_%0d", g), bout[g], e[22:0]);
          if (g == 0 && nv < 8) begin
            vcyc[nv] = cyc;
            nv++;
          end
        end
      end
    end
  end

  function automatic longint unsigned half_ref(input longint unsigned v);
    return (v % 2 == 1) ? (v + Q) / 2 : v / 2;
  endfunction

  // Butterfly order per frame: block m upper pairs, then block m lower pairs.
  task automatic drive_frame(input int g, input logic [22:0] u [8], input logic [22:0] l [8],
                             input int gm);
    int k, c, ord, d, fp;
    longint unsigned x, y, z, a, b;
    bit acc;
    d = DV[g];
    fp = FPV[g];
    ord = 0;
    for (int m = 0; m < fp / (2 * d); m++) begin
      for (int h = 0; h < 2; h++) begin
        for (int j = 0; j < d; j++) begin
          x = (h == 0) ? u[2*d*m+j]   : l[2*d*m+j];
          y = (h == 0) ? u[2*d*m+d+j] : l[2*d*m+d+j];
          z = rom[g][ord];
          ord++;
          a = (x + y) % Q;
          b = (((x + Q - y) % Q) * z) % Q;
`ifdef GS_DIV2_EN
          a = half_ref(a);
          b = half_ref(b);
`endif
          expbuf[g][wr[g] % 64] = {a[22:0], b[22:0]};
          wr[g]++;
        end
      end
    end
    k = 0;
    c = 0;
    while (k < fp && c < 400) begin
      en[g]  = (gm == 0) || (gm == 1 && c % 2 == 0) || (gm == 2 && $urandom_range(0, 1) == 1);
      ain[g] = u[k];
      bin[g] = l[k];
      acc = en[g] && rdy[g];
      if (acc) acc_last = cyc;
      @(negedge clk);
      if (acc) k++;
      c++;
    end
    en[g] = 1'b0;
    if (k < fp) check_val("accept_timeout", k, fp);
  endtask

  task automatic rand_frame(input int g, input int gm);
    logic [22:0] u [8];
    logic [22:0] l [8];
    for (int i = 0; i < 8; i++) begin
      u[i] = 23'($urandom_range(0, 8380416));
      l[i] = 23'($urandom_range(0, 8380416));
    end
    drive_frame(g, u, l, gm);
  endtask

  task automatic rand_rom(input int g);
    for (int i = 0; i < 8; i++) rom[g][i] = 23'($urandom_range(0, 8380416));
  endtask

  task automatic wait_drain(input int g);
    for (int i = 0; i < 80 && rd[g] != wr[g]; i++) @(negedge clk);
    check_val($sformatf("drain_done_%0d", g), wr[g] - rd[g], 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic count_ready_low(input int g);
    int cnt;
    cnt = 0;
    for (int i = 0; i < 2 * DV[g] + 2; i++) begin
      if (!rdy[g]) cnt++;
      @(negedge clk);
    end
    check_val($sformatf("ready_low_cycles_%0d", g), cnt, DV[g]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [22:0] u [8];
    logic [22:0] l [8];
    rst_n = 1'b0;
    for (int g = 0; g < NI; g++) begin
      en[g] = 1'b0;
      ain[g] = '0;
      bin[g] = '0;
      for (int i = 0; i < 8; i++) rom[g][i] = 23'd1;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int g = 0; g < NI; g++) begin
      check_val("rst_valid", vld[g], 0);
      check_val("rst_in_ready", rdy[g], 1);
      check_val("rst_tw_idx", tw[g], 0);
      check_val("rst_A_out", aout[g], 0);
      check_val("rst_B_out", bout[g], 0);
    end

    // D=1 two-pair frame: latency and single drain cycle
    u = '{1, 2, 0, 0, 0, 0, 0, 0};
    l = '{3, 4, 0, 0, 0, 0, 0, 0};
    nv = 0;
    drive_frame(0, u, l, 0);
    count_ready_low(0);
    wait_drain(0);
    check_val("n_outputs", nv, 2);
    check_val("latency_first", vcyc[0] - acc_last, 3);
    check_val("latency_drain", vcyc[1] - acc_last, 4);

    rom[0][0] = 23'd2;
    rom[0][1] = 23'd1;
    u = '{5, 3, 0, 0, 0, 0, 0, 0};
    l = '{8380416, 5, 0, 0, 0, 0, 0, 0};
    drive_frame(0, u, l, 0);
    wait_drain(0);

    rom[0][0] = 23'd1;
    u = '{1, 2, 0, 0, 0, 0, 0, 0};
    l = '{10, 4, 0, 0, 0, 0, 0, 0};
    drive_frame(0, u, l, 0);
    wait_drain(0);

    rand_rom(0);
    for (int f = 0; f < 6; f++) rand_frame(0, 2);
    wait_drain(0);

    // D=4 eight-pair frame: ramp stream, then alternating en gaps, then random
    for (int i = 0; i < 8; i++) begin
      u[i] = 23'(i);
      l[i] = 23'(100 + i);
    end
    drive_frame(1, u, l, 0);
    count_ready_low(1);
    wait_drain(1);
    drive_frame(1, u, l, 1);
    wait_drain(1);
    rand_rom(1);
    for (int f = 0; f < 5; f++) rand_frame(1, f % 3);
    wait_drain(1);

    // D=2: reset on the n-th accept discards everything in flight
    for (int n = 3; n <= 5; n += 2) begin
      rand_rom(2);
      for (int i = 0; i < n; i++) begin
        en[2]  = 1'b1;
        ain[2] = 23'($urandom_range(0, 8380416));
        bin[2] = 23'($urandom_range(0, 8380416));
        if (i == n - 1) rst_n = 1'b0;
        @(negedge clk);
      end
      en[2] = 1'b0;
      rst_n = 1'b1;
      check_val("post_rst_ready", rdy[2], 1);
      check_val("post_rst_tw_idx", tw[2], 0);
      for (int i = 0; i < 5; i++) begin
        check_val("post_rst_valid", vld[2], 0);
        @(negedge clk);
      end
      rand_frame(2, 0);
      rand_frame(2, 2);
      wait_drain(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gs_r2mdc.md
# gs_r2mdc

Radix-2 multi-path delay commutator stage for the inverse NTT. It accepts two coefficient streams and reorders them through input-side delay lines so that each butterfly sees samples D apart. It then applies a Gentleman-Sande butterfly: sum first, then multiply the difference by zeta, mod q. It is the inverse-direction counterpart of the forward Cooley-Tukey MDC stage, and stages are chained with D halving along the INTT pipeline.

## Interface
- DATA_W, 23: coefficient width. Values are unsigned in [0, Q).
- Q, 8380417: modulus.
- D, 1: commutator delay in pairs. Must be a power of two, at least 1.
- FRAME_PAIRS, 128: input pairs per frame. Must be a multiple of 2·D.
- clk  in  1: clock. All logic is on the rising edge.
- reset  in  1: synchronous, active-low reset.
- en  in  1: input pair valid.
- in_ready  out  1: stage can accept a pair. A pair is accepted when en and in_ready are both high.
- A_in, B_in  in  DATA_W: upper-path sample u[k] and lower-path sample l[k].
- tw_idx  out  $clog2(FRAME_PAIRS): butterfly index of the pair issued this cycle. It drives an external asynchronous-read twiddle ROM.
- zeta  in  DATA_W: twiddle for tw_idx. It is sampled in the issue cycle.
- A_out, B_out  out  DATA_W: butterfly results.
- valid  out  1: A_out and B_out are valid. The output has no backpressure.

## Operation
- States:
  - IDLE: in_ready=1. The first accept moves to RUN.
  - RUN: in_ready=1. The FRAME_PAIRS-th accept moves to DRAIN.
  - DRAIN: in_ready=0 for exactly D cycles, then back to IDLE.
- Pair counter k counts accepts within the frame. For k = 2D·m + s·D + j:
  - m is the block index.
  - s is the half-select bit, bit log2(D) of k.
  - j is in [0, D).
- Issue schedule:
  - Accept with s=1: issue the upper pair x=u[2Dm+j], y=u[2Dm+D+j]. y is the sample arriving this cycle.
  - Accept with s=0 and m≥1: issue the lower pair x=l[2D(m-1)+j], y=l[2D(m-1)+D+j].
  - Accept with s=0 and m=0: no issue.
  - DRAIN cycle j: issue the lower pair of the last block, index j.
- Every frame issues exactly FRAME_PAIRS butterflies.
- tw_idx is the issue ordinal within the frame, 0..FRAME_PAIRS-1.
- Delay lines shift only on accept, plus on DRAIN cycles for the lower path. Gaps in en stall the stage without loss.
- Butterfly:
  - A = (x+y) mod Q.
  - B = ((x−y) mod Q · zeta) mod Q.
  - Subtraction adds Q on borrow. Addition subtracts Q when the sum is ≥ Q.
  - Product width is 2·DATA_W. Reduction is exact.
- en while in_ready=0 is ignored; the pair is lost and the source must hold it.

## Timing
- Butterfly pipeline has 3 registers:
  - P1: add/sub mod Q, with zeta captured.
  - P2: product.
  - P3: reduction to A_out and B_out.
- An issue in cycle t gives valid=1 in cycle t+3.
- First output appears D+3 cycles after the first accept when en is held high.
- Back-to-back frames:
  - The last accept in cycle t is followed by DRAIN in t+1..t+D.
  - The next accept is possible in t+D+1.
- Reset (reset=0 at a clock edge):
  - State becomes IDLE, k=0, in_ready=1.
  - valid, A_out, B_out, tw_idx and all pipeline valids become 0.
  - Delay-line data is not cleared; its contents are don't-care.
  - A reset mid-frame or mid-DRAIN discards the partial frame and any in-flight results. No valid is produced after reset until a new issue.

## Configuration
- GS_DIV2_EN:
  - Defined: P3 additionally halves A and B mod Q. Even v gives v/2; odd v gives (v+Q)/2. Latency is unchanged. Eight chained stages give the 1/256 INTT scaling.
  - Undefined: no halving.

## Structure
- Package ntt_pkg holds Q, DATA_W, the state enum (IDLE/RUN/DRAIN), and add/sub-mod-Q functions.
- The single sub-module is mod_red: registered (2·DATA_W)→DATA_W reduction mod Q. It forms stage P3, with the optional halving following it.

## Test plan
- D=1, FRAME_PAIRS=2, zeta=1.
  - Stimulus: (A_in,B_in) = (1,3) then (2,4).
  - Outputs, in order:
    - (3, 8380416) at 3 cycles after the second accept.
    - (7, 8380416) one cycle later, from the DRAIN issue.
  - in_ready=0 for exactly 1 cycle.
- Butterfly arithmetic: x=5, y=3, zeta=2 → A=8, B=4. x=8380416, y=5, zeta=1 → A=4, B=8380411.
- D=4, FRAME_PAIRS=8:
  - Stimulus: u[k]=k, l[k]=100+k, zeta=1.
  - Issue order: upper (0,4),(1,5),(2,6),(3,7), then lower (100,104)…(103,107).
  - tw_idx runs 0..7.
  - Output A values: 4,6,8,10,204,206,208,210.
- Same stream as the D=4 case with en low on alternating cycles → identical output sequence, stretched in time. No lost pairs.
- GS_DIV2_EN with x=1, y=2, zeta=1 → A=4190210, B=4190208.
- Reset asserted on the 3rd accept of a D=2 frame → valid=0 from the next cycle. A fresh frame afterwards produces results equal to a clean run.
